// File: rtl/y86_mem_pkg.sv
// Shared encodings for the Y86 memory arbiter: FSM states, grant owner and access lengths.
package y86_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_FBEAT0 = 3'd2,
        ST_FBEAT1 = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_e;

    localparam logic [3:0] FETCH_LEN = 4'd10;
    localparam logic [3:0] DATA_LEN  = 4'd8;

endpackage

// File: rtl/y86_range_check.sv
// Combinational bounds check: flags addr+len > MEM_BYTES, evaluated in 65 bits so address wrap is an error.
module y86_range_check #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic [63:0] addr_i,
    input  logic [3:0]  len_i,
    output logic        err_o
);

    logic [64:0] end_addr;

    assign end_addr = {1'b0, addr_i} + {61'd0, len_i};
    assign err_o    = end_addr > 65'(MEM_BYTES);

endmodule

// File: rtl/y86_mem_arbiter.sv
// Arbitrates one single-port 64-bit memory between the fetch stage (two-beat 10-byte fetch) and the M stage.
// Optional build macro MEM_TIMEOUT_EN adds a per-beat timeout that aborts the access with an error.
module y86_mem_arbiter
    import y86_mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 15
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_req,
    input  logic [63:0] f_addr,
    output logic [79:0] f_bytes,
    output logic        f_done,
    output logic        f_err,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [63:0] m_addr,
    input  logic [63:0] m_wdata,
    output logic [63:0] m_rdata,
    output logic        m_done,
    output logic        m_err,
    output logic        f_stall,
    output logic        m_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ready
);

    state_e      state_q, state_d;
    grant_e      last_grant_q, last_grant_d;
    grant_e      cur_q, cur_d;
    logic [63:0] fbuf_q, fbuf_d;
    logic [79:0] f_bytes_q, f_bytes_d;
    logic [63:0] m_rdata_q, m_rdata_d;
    logic        f_err_q, f_err_d;
    logic        m_err_q, m_err_d;

    logic        pick_data;
    logic [63:0] win_addr;
    logic [3:0]  win_len;
    logic        range_err;
    logic        in_beat;
    logic        tmo_hit;

    // Data wins by default; fetch wins only right after a data grant so neither side starves.
    assign pick_data = m_req && !(last_grant_q == GNT_DATA && f_req);
    assign win_addr  = pick_data ? m_addr   : f_addr;
    assign win_len   = pick_data ? DATA_LEN : FETCH_LEN;

    y86_range_check #(.MEM_BYTES(MEM_BYTES)) u_range_check (
        .addr_i (win_addr),
        .len_i  (win_len),
        .err_o  (range_err)
    );

    assign in_beat = (state_q == ST_DATA) || (state_q == ST_FBEAT0) || (state_q == ST_FBEAT1);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    // Restart on every state change so each beat gets its own TIMEOUT budget.
    assign tmo_d   = (state_d != state_q)        ? '0 :
                     (in_beat && !mem_ready)     ? tmo_q + 1'b1 : tmo_q;
    assign tmo_hit = in_beat && !mem_ready && (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_DATA: begin
                mem_req   = 1'b1;
                mem_we    = m_we;
                mem_addr  = m_addr;
                mem_wdata = m_wdata;
            end
            ST_FBEAT0: begin
                mem_req  = 1'b1;
                mem_addr = f_addr;
            end
            ST_FBEAT1: begin
                mem_req  = 1'b1;
                mem_addr = f_addr + 64'd8;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_d        = cur_q;
        fbuf_d       = fbuf_q;
        f_bytes_d    = f_bytes_q;
        m_rdata_d    = m_rdata_q;
        f_err_d      = f_err_q;
        m_err_d      = m_err_q;
        case (state_q)
            ST_IDLE: begin
                if (f_req || m_req) begin
                    cur_d = pick_data ? GNT_DATA : GNT_FETCH;
                    if (range_err) begin
                        state_d = ST_RESP;
                        if (pick_data) begin
                            m_err_d   = 1'b1;
                            m_rdata_d = '0;
                        end else begin
                            f_err_d   = 1'b1;
                            f_bytes_d = '0;
                        end
                    end else begin
                        state_d = pick_data ? ST_DATA : ST_FBEAT0;
                    end
                end
            end
            ST_DATA: begin
                if (mem_ready) begin
                    if (!m_we) m_rdata_d = mem_rdata;
                    m_err_d = 1'b0;
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    m_rdata_d = '0;
                    m_err_d   = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_FBEAT0: begin
                if (mem_ready) begin
                    fbuf_d  = mem_rdata;
                    state_d = ST_FBEAT1;
                end else if (tmo_hit) begin
                    f_bytes_d = '0;
                    f_err_d   = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_FBEAT1: begin
                if (mem_ready) begin
                    f_bytes_d = {mem_rdata[15:0], fbuf_q};
                    f_err_d   = 1'b0;
                    state_d   = ST_RESP;
                end else if (tmo_hit) begin
                    f_bytes_d = '0;
                    f_err_d   = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                last_grant_d = cur_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_FETCH;
            cur_q        <= GNT_FETCH;
            fbuf_q       <= '0;
            f_bytes_q    <= '0;
            m_rdata_q    <= '0;
            f_err_q      <= 1'b0;
            m_err_q      <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_q        <= cur_d;
            fbuf_q       <= fbuf_d;
            f_bytes_q    <= f_bytes_d;
            m_rdata_q    <= m_rdata_d;
            f_err_q      <= f_err_d;
            m_err_q      <= m_err_d;
        end
    end

    assign f_done  = (state_q == ST_RESP) && (cur_q == GNT_FETCH);
    assign m_done  = (state_q == ST_RESP) && (cur_q == GNT_DATA);
    assign f_bytes = f_bytes_q;
    assign f_err   = f_err_q;
    assign m_rdata = m_rdata_q;
    assign m_err   = m_err_q;

    // Stalls are gated by reset so every output reads 0 while rst_n is low.
    assign f_stall = rst_n && f_req && !f_done;
    assign m_stall = rst_n && m_req && !m_done;

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Directed self-checking bench for y86_mem_arbiter with a configurable-wait memory responder.
module tb_y86_mem_arbiter;

    localparam int unsigned MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req, m_req, m_we;
    logic [63:0] f_addr, m_addr, m_wdata;
    logic [79:0] f_bytes;
    logic [63:0] m_rdata;
    logic        f_done, f_err, m_done, m_err, f_stall, m_stall;
    logic        mem_req, mem_we, mem_ready;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    y86_mem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_bytes(f_bytes), .f_done(f_done), .f_err(f_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_done(m_done), .m_err(m_err),
        .f_stall(f_stall), .m_stall(m_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int          wait_cfg = 0;
    int          beat_idx = 0;
    int          mem_req_cnt = 0;
    int          f_done_cnt = 0;
    logic [63:0] vals [8];
    logic [63:0] log_addr [8];
    logic        log_we [8];
    logic [63:0] log_wdata [8];

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: ready after wait_cfg low cycles of each beat, returns vals[] in beat order.
    initial begin
        int wcnt;
        wcnt      = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) mem_req_cnt++;
            if (f_done)  f_done_cnt++;
            if (mem_ready) begin
                mem_ready = 1'b0;
                wcnt      = 0;
            end
            if (mem_req) begin
                if (wcnt == wait_cfg) begin
                    mem_ready               = 1'b1;
                    mem_rdata               = vals[beat_idx % 8];
                    log_addr[beat_idx % 8]  = mem_addr;
                    log_we[beat_idx % 8]    = mem_we;
                    log_wdata[beat_idx % 8] = mem_wdata;
                    beat_idx++;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the 1-based cycle in which the selected done pulse is seen, or 0 if the budget expires.
    task automatic wait_done(input bit is_fetch, input int budget, output int cyc);
        cyc = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (is_fetch ? f_done : m_done) begin
                cyc = i;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int          cyc, b, mc, fc, n;
        logic [5:0]  order;
        logic [63:0] a_val, b_val;

        rst_n = 1'b0; f_req = 1'b0; m_req = 1'b0; m_we = 1'b0;
        f_addr = '0; m_addr = '0; m_wdata = '0;
        #23;
        check("rst_mem_req", 80'(mem_req), 80'd0);
        check("rst_dones",   80'({f_done, m_done}), 80'd0);
        check("rst_f_bytes", f_bytes, 80'd0);
        check("rst_m_rdata", 80'(m_rdata), 80'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Zero-wait data read
        b = beat_idx; fc = f_done_cnt;
        vals[b % 8] = 64'h1122334455667788;
        wait_cfg = 0;
        m_req = 1'b1; m_we = 1'b0; m_addr = 64'd16;
        #1 check("rd_m_stall", 80'(m_stall), 80'd1);
        wait_done(1'b0, 20, cyc);
        check("rd_cycles", 80'(cyc), 80'd3);
        check("rd_rdata",  80'(m_rdata), 80'h1122334455667788);
        check("rd_err",    80'(m_err), 80'd0);
        check("rd_stall_at_done", 80'(m_stall), 80'd0);
        check("rd_mem_addr", 80'(log_addr[b % 8]), 80'd16);
        tick(); m_req = 1'b0;
        check("rd_no_fdone", 80'(f_done_cnt - fc), 80'd0);

        // Fetch against 2-cycle-per-beat memory
        b = beat_idx;
        a_val = 64'h0807060504030201; b_val = 64'hDEADBEEFCAFE0A09;
        vals[b % 8] = a_val; vals[(b + 1) % 8] = b_val;
        wait_cfg = 1;
        f_req = 1'b1; f_addr = 64'h20;
        wait_done(1'b1, 30, cyc);
        check("fe_cycles", 80'(cyc), 80'd6);
        check("fe_bytes",  f_bytes, {16'h0A09, a_val});
        check("fe_err",    80'(f_err), 80'd0);
        check("fe_addr0",  80'(log_addr[b % 8]), 80'h20);
        check("fe_addr1",  80'(log_addr[(b + 1) % 8]), 80'h28);
        check("fe_we",     80'({log_we[b % 8], log_we[(b + 1) % 8]}), 80'd0);
        tick(); f_req = 1'b0;
        tick();

        // Range checks: no beat may be issued on an error
        wait_cfg = 0;
        mc = mem_req_cnt;
        m_req = 1'b1; m_addr = 64'(MEM_BYTES - 4);
        wait_done(1'b0, 20, cyc);
        check("rng_m_cycles", 80'(cyc), 80'd2);
        check("rng_m_err",    80'(m_err), 80'd1);
        check("rng_m_nobeat", 80'(mem_req_cnt - mc), 80'd0);
        tick(); m_req = 1'b0;
        b = beat_idx; vals[b % 8] = 64'h55AA55AA55AA55AA;
        m_req = 1'b1; m_addr = 64'(MEM_BYTES - 8);
        wait_done(1'b0, 20, cyc);
        check("rng_edge_cycles", 80'(cyc), 80'd3);
        check("rng_edge_err",    80'(m_err), 80'd0);
        check("rng_edge_rdata",  80'(m_rdata), 80'h55AA55AA55AA55AA);
        tick(); m_req = 1'b0;
        mc = mem_req_cnt;
        f_req = 1'b1; f_addr = 64'hFFFF_FFFF_FFFF_FFFA;
        wait_done(1'b1, 20, cyc);
        check("rng_wrap_cycles", 80'(cyc), 80'd2);
        check("rng_wrap_err",    80'(f_err), 80'd1);
        tick(); f_addr = 64'(MEM_BYTES - 9);
        wait_done(1'b1, 20, cyc);
        check("rng_f_cycles", 80'(cyc), 80'd2);
        check("rng_f_err",    80'(f_err), 80'd1);
        check("rng_f_nobeat", 80'(mem_req_cnt - mc), 80'd0);
        tick(); f_req = 1'b0;

        // Simultaneous requests after a fetch grant: data first, then fetch
        b = beat_idx; fc = f_done_cnt;
        vals[(b + 1) % 8] = 64'h1716151413121110; vals[(b + 2) % 8] = 64'h0000000000001918;
        f_req = 1'b1; f_addr = 64'h80;
        m_req = 1'b1; m_we = 1'b1; m_addr = 64'h40; m_wdata = 64'hA5A5_0000_FFFF_1234;
        wait_done(1'b0, 20, cyc);
        check("arb_m_first",  80'(cyc), 80'd3);
        check("arb_wr_we",    80'(log_we[b % 8]), 80'd1);
        check("arb_wr_data",  80'(log_wdata[b % 8]), 80'hA5A5_0000_FFFF_1234);
        check("arb_wr_addr",  80'(log_addr[b % 8]), 80'h40);
        tick(); m_req = 1'b0; m_we = 1'b0;
        check("arb_f_waited", 80'(f_done_cnt - fc), 80'd0);
        wait_done(1'b1, 20, cyc);
        check("arb_f_cycles", 80'(cyc), 80'd4);
        check("arb_f_bytes",  f_bytes, 80'h1918_1716151413121110);
        tick();

        // Both requests held continuously: grants must alternate D,F,D,F,D,F
        m_req = 1'b1; m_addr = 64'h100;
        n = 0; order = '0;
        for (int i = 0; i < 80 && n < 6; i++) begin
            @(negedge clk);
            if (m_done) begin order[n] = 1'b1; n++; end
            else if (f_done) begin order[n] = 1'b0; n++; end
            tick();
        end
        check("alt_count", 80'(n), 80'd6);
        check("alt_order", 80'(order), 80'b010101);
        f_req = 1'b0; m_req = 1'b0;
        tick(); tick();

        // Reset during the second fetch beat
        wait_cfg = 3;
        f_req = 1'b1; f_addr = 64'h100;
        repeat (6) tick();
        @(negedge clk);
        check("rb_in_fbeat1", 80'({mem_req, mem_addr}), {15'd0, 1'b1, 64'h108});
        fc = f_done_cnt;
        #1 rst_n = 1'b0;
        #1;
        check("rb_mem_req", 80'(mem_req), 80'd0);
        check("rb_outputs", 80'({f_done, f_err, f_stall, m_done, m_err, m_stall}), 80'd0);
        check("rb_f_bytes", f_bytes, 80'd0);
        tick(); tick();
        b = beat_idx;
        vals[b % 8] = 64'h3736353433323130; vals[(b + 1) % 8] = 64'h0000000000003938;
        rst_n = 1'b1;
        wait_done(1'b1, 40, cyc);
        check("rb_restart_cycles", 80'(cyc), 80'd10);
        check("rb_restart_addr",   80'(log_addr[b % 8]), 80'h100);
        check("rb_restart_bytes",  f_bytes, 80'h3938_3736353433323130);
        tick(); f_req = 1'b0;
        check("rb_one_fdone", 80'(f_done_cnt - fc), 80'd1);
        wait_cfg = 0;
        tick();

`ifdef MEM_TIMEOUT_EN
        // Memory never ready: 1 grant + 15 wait cycles + 1 response
        wait_cfg = 1000;
        m_req = 1'b1; m_we = 1'b0; m_addr = 64'h0;
        wait_done(1'b0, 40, cyc);
        check("tmo_cycles",  80'(cyc), 80'd17);
        check("tmo_err",     80'(m_err), 80'd1);
        check("tmo_rdata",   80'(m_rdata), 80'd0);
        check("tmo_mem_req", 80'(mem_req), 80'd0);
        tick(); m_req = 1'b0;
        wait_cfg = 0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/y86_mem_arbiter.md
Name: y86_mem_arbiter

Overview:
- Shares one 64-bit single-port memory between the pipeline's fetch stage (10-byte instruction fetch) and the M stage (8-byte data read/write).
- Sequences each fetch as two memory beats and grants requesters by priority with anti-starvation.
- Performs address-range checks and drives the stall/done signals consumed by the pipeline control logic.
- Sits between the pipelined core and the memory model.

Parameters:
- MEM_BYTES, 1024: size of the byte-addressable memory; accesses beyond it are errors.
- TIMEOUT, 15: cycles allowed per memory beat before abort (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch request; held until f_done.
- f_addr  in  64  fetch byte address (f_pc); stable while f_req high.
- f_bytes  out  80  fetched bytes; byte i (addr+i) at bits [8i+7:8i]; valid when f_done is high.
- f_done  out  1  one-cycle pulse when the fetch completes.
- f_err  out  1  valid with f_done; range error (imem_error).
- m_req  in  1  data request; held until m_done.
- m_we  in  1  1 = write, 0 = read; stable with m_req.
- m_addr  in  64  data byte address.
- m_wdata  in  64  write data.
- m_rdata  out  64  read data; valid when m_done is high.
- m_done  out  1  one-cycle completion pulse.
- m_err  out  1  valid with m_done; range error (dmem_error).
- f_stall  out  1  f_req high and f_done low.
- m_stall  out  1  m_req high and m_done low.
- mem_req  out  1  memory beat request; held until mem_ready.
- mem_we  out  1  beat is a write.
- mem_addr  out  64  beat byte address; unaligned allowed.
- mem_wdata  out  64  beat write data.
- mem_rdata  in  64  8 bytes starting at mem_addr; valid when mem_ready is high.
- mem_ready  in  1  beat complete.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, last_grant = FETCH.
  - All outputs 0, including mem_req, which drops immediately.
  - Any in-flight beat is abandoned; no done pulse is issued for it.
- States: IDLE, DATA, FBEAT0, FBEAT1, RESP.
- IDLE, arbitration:
  - Data wins if m_req is high, unless last_grant == DATA and f_req is high; in that case fetch wins.
  - The winner is range-checked first.
  - On range fail (addr+len > MEM_BYTES, len = 8 for data, 10 for fetch, computed in 65 bits so wrap counts as a fail): go to RESP with the err flag set. No memory beat is issued.
  - Otherwise go to DATA or FBEAT0. mem_req asserts on the cycle after the grant.
- DATA:
  - mem_addr = m_addr, mem_we = m_we, mem_wdata = m_wdata.
  - On mem_ready: capture mem_rdata (reads), go to RESP.
- FBEAT0:
  - mem_addr = f_addr, mem_we = 0.
  - On mem_ready: capture rdata as bytes 0-7, go to FBEAT1.
- FBEAT1:
  - mem_addr = f_addr+8.
  - On mem_ready: capture rdata[15:0] as bytes 8-9, go to RESP.
- RESP:
  - Pulse f_done or m_done (exactly one) with registered data and err.
  - Update last_grant, return to IDLE.
- Latency:
  - Data access: 1 (grant) + N (beat) + 1 (resp).
  - Fetch: 2 + N0 + N1.
  - With zero-wait memory (mem_ready high on the first cycle of mem_req): data completes in 3 cycles, fetch in 4.
- At most one mem_req beat is outstanding; mem_req deasserts for at least the RESP cycle between accesses.
- A requester keeping req high after done is treated as a new request in the next IDLE cycle.
- Address or data changes while a request is pending are undefined; the bench checks stability.
- f_bytes, m_rdata and the err flags hold their last value outside done pulses.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With it:
  - A counter resets on each beat start and increments while mem_req is high and mem_ready is low.
  - On reaching TIMEOUT: drop mem_req, go to RESP with the active requester's err set (f_err or m_err), data 0.
- Without it: waits indefinitely for mem_ready; no counter logic.

Decomposition:
- Package y86_mem_pkg:
  - State encoding (3 bits: IDLE=0, DATA=1, FBEAT0=2, FBEAT1=3, RESP=4).
  - Grant encoding (FETCH=0, DATA=1).
  - FETCH_LEN=10, DATA_LEN=8.
- One sub-module: y86_range_check (combinational addr+len vs MEM_BYTES, 65-bit), instantiated once on the winner's address.

Test Plan:
- Zero-wait data read: m_req, m_we=0, m_addr=16, mem returns 64'h1122334455667788 -> m_done at cycle 3, m_rdata=64'h1122334455667788, m_err=0, f_done never pulses.
- Fetch with 2-cycle-wait memory: f_addr=0x20, beats return A then B -> mem_addr sequence 0x20, 0x28; f_bytes={B[15:0],A}, f_done at cycle 6.
- Simultaneous f_req and m_req with last_grant=FETCH -> data served first (m_done), then the fetch; repeat with m_req held continuously -> fetch and data alternate grants, no starvation.
- Range error: m_addr=MEM_BYTES-4 -> m_done with m_err=1 two cycles after request, mem_req never asserted; f_addr=64'hFFFF_FFFF_FFFF_FFFA (wraps) -> f_err=1.
- Reset mid-beat: drop rst_n during FBEAT1 -> mem_req and all outputs 0 immediately, no f_done; after release, the pending f_req restarts from FBEAT0.
- With MEM_TIMEOUT_EN, TIMEOUT=15: mem_ready stuck low -> m_done with m_err=1 after 15 wait cycles, mem_req dropped.
